instr_sequencer: RTL and testbench

Sequences the processor datapath from a synchronous program memory. It owns the 2-bit timestep counter consumed by the processor controller and drives the external data word, meaning the instruction or LOAD operand, that the controller latches when it asserts Ext. It fetches words in order from a program counter and stalls the timestep while a word is refilled. It supports free-run, single-instruction step, halt at instruction boundary, and PC preload while idle.

---
 rtl/instr_sequencer_pkg.sv | 18 +
 rtl/instr_sequencer_timestep_counter.sv | 22 ++
 rtl/instr_sequencer.sv | 126 ++++++++++++
 tb/tb_instr_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer, its timestep
// counter, and the memory/controller wrappers.
package seq_pkg;

  localparam int unsigned SEQ_ADDR_W = 6;
  localparam int unsigned SEQ_DATA_W = 10;
  localparam int unsigned TS_W       = 2;

  localparam logic [TS_W-1:0] TS_START = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    EXEC  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_timestep_counter.sv
// Wrapping timestep counter with synchronous clear taking priority over enable.
module timestep_counter
  import seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  output logic [TS_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= TS_START;
    end else if (clear) begin
      count <= TS_START;
    end else if (enable) begin
      count <= count + TS_W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetches program words in order, presents them to the controller on data_o
// and owns the timestep, stalling it while the next word is refilled.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned ADDR_W = SEQ_ADDR_W,
  parameter int unsigned DATA_W = SEQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ext,
  input  logic              clr,
  output logic [TS_W-1:0]   timestep,
  output logic [DATA_W-1:0] data_o,
  output logic              busy,
  output logic              instr_done
);

  seq_state_t        state;
  seq_state_t        next_state;
  logic [ADDR_W-1:0] pc;
  logic              single_q;
  logic              stop_c;
  logic              in_idle_c;
  logic              in_exec_c;
  logic              done_c;
  logic              start_c;

  assign in_idle_c = (state == IDLE);
  assign in_exec_c = (state == EXEC);
  assign stop_c    = single_q | ~run;
  assign done_c    = in_exec_c & clr;
  assign start_c   = in_idle_c & (run | step);
  assign mem_addr  = pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: stop at the clr boundary takes priority over a refill on ext
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (run || step) begin
          next_state = FETCH;
        end
      end
      FETCH: next_state = WAIT;
      WAIT:  next_state = EXEC;
      EXEC: begin
        if (clr && stop_c) begin
          next_state = IDLE;
        end else if (ext) begin
          next_state = FETCH;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Program counter: preload only while idle, advance on each consumed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (in_idle_c && pc_load) begin
      pc <= pc_load_val;
    end else if (in_exec_c && ext) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  // Single-step flag lives from the step launch to the instruction's clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_q <= 1'b0;
    end else if (start_c) begin
      single_q <= ~run;
    end else if (done_c && stop_c) begin
      single_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o <= '0;
    end else if (state == WAIT) begin
      data_o <= mem_rdata;
    end
  end

  // Registered status/strobe outputs track the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      mem_rd_en  <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      busy       <= (next_state != IDLE);
      mem_rd_en  <= (next_state == FETCH);
      instr_done <= done_c;
    end
  end

  // clr is only honoured in EXEC so stray pulses during a refill cannot rewind it
  timestep_counter u_timestep (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (in_idle_c | done_c),
    .enable (in_exec_c),
    .count  (timestep)
  );

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-cycle vectors for control
// outputs and a word scoreboard for data_o after every refill.
module tb_instr_sequencer;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          step;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rdata;
  logic          ext;
  logic          clr;
  logic [1:0]    timestep;
  logic [DW-1:0] data_o;
  logic          busy;
  logic          instr_done;

  instr_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .ext         (ext),
    .clr         (clr),
    .timestep    (timestep),
    .data_o      (data_o),
    .busy        (busy),
    .instr_done  (instr_done)
  );

  always #5 clk = ~clk;

  // Synchronous program memory: data valid the cycle after the read strobe
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] sb_exp;
  logic          rd_p1 = 1'b0;
  logic          rd_p2 = 1'b0;

  typedef struct {
    logic          run, step, ld;
    logic [AW-1:0] val;
    logic          ext, clr;
    logic          busy;
    logic [1:0]    ts;
    logic [AW-1:0] addr;
    logic          rd, done, refill;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input string sig, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %0d expected %0d", name, sig, act, exp);
    end
  endtask

  function automatic vec_t mk(input int r, input int s, input int l, input int v,
                              input int e, input int c, input int b, input int ts,
                              input int a, input int rd, input int dn, input int rf);
    vec_t x;
    x.run = 1'(r);  x.step = 1'(s); x.ld = 1'(l); x.val = AW'(v);
    x.ext = 1'(e);  x.clr = 1'(c);  x.busy = 1'(b); x.ts = 2'(ts);
    x.addr = AW'(a); x.rd = 1'(rd); x.done = 1'(dn); x.refill = 1'(rf);
    return x;
  endfunction

  // Drive one cycle of inputs, then check the registered outputs after the edge
  task automatic apply(input vec_t v, input string name);
    run = v.run; step = v.step; pc_load = v.ld; pc_load_val = v.val;
    ext = v.ext; clr = v.clr;
    @(posedge clk); #1;
    chk(name, "busy",       32'(busy),       32'(v.busy));
    chk(name, "timestep",   32'(timestep),   32'(v.ts));
    chk(name, "mem_addr",   32'(mem_addr),   32'(v.addr));
    chk(name, "mem_rd_en",  32'(mem_rd_en),  32'(v.rd));
    chk(name, "instr_done", 32'(instr_done), 32'(v.done));
    if (v.refill) sb_q.push_back(mem[v.addr]);
  endtask

  // Two cycles after a FETCH the refilled word must be on data_o
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      rd_p1 = 1'b0;
      rd_p2 = 1'b0;
    end else begin
      if (rd_p2) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb data_o: got %0d with no expected word queued", data_o);
        end else begin
          sb_exp = sb_q.pop_front();
          chk("sb", "data_o", 32'(data_o), 32'(sb_exp));
        end
      end
      rd_p2 = rd_p1;
      rd_p1 = mem_rd_en;
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = DW'(i * 37 + 11);
    mem[4] = 10'h2A5;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; pc_load = 1'b0; pc_load_val = '0;
    ext = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "busy",      32'(busy),      0);
    chk("reset", "timestep",  32'(timestep),  0);
    chk("reset", "mem_addr",  32'(mem_addr),  0);
    chk("reset", "mem_rd_en", 32'(mem_rd_en), 0);
    chk("reset", "data_o",    32'(data_o),    0);
    rst_n = 1'b1;

    // COPY at 5/6 in free run, then LOAD at 3 with operand at 4
    tbl.push_back(mk(0,0,1,5, 0,0, 0,0,5,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,0,5,1,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,0,5,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,0,5,0,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0, 1,1,6,1,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,1,6,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,1,6,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,1, 1,0,6,0,1,0));
    tbl.push_back(mk(0,0,1,9, 0,0, 1,1,6,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,1, 0,0,6,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,6,0,0,0));
    tbl.push_back(mk(0,0,1,3, 0,0, 0,0,3,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,0,3,1,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,0,3,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,0,3,0,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0, 1,1,4,1,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,1,4,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 1,1,4,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1, 0,0,5,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,5,0,0,0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Step with simultaneous preload; run rising mid-step must not extend it
    apply(mk(0,1,1,0, 0,0, 1,0,0,1,0,1), "step_a0");
    apply(mk(0,0,0,0, 0,0, 1,0,0,0,0,0), "step_a1");
    apply(mk(0,0,0,0, 0,0, 1,0,0,0,0,0), "step_a2");
    apply(mk(0,0,0,0, 1,0, 1,1,1,1,0,1), "step_a3");
    apply(mk(0,0,0,0, 0,0, 1,1,1,0,0,0), "step_a4");
    apply(mk(0,0,0,0, 0,0, 1,1,1,0,0,0), "step_a5");
    apply(mk(0,0,0,0, 0,0, 1,2,1,0,0,0), "step_a6");
    apply(mk(1,0,0,0, 0,0, 1,3,1,0,0,0), "step_a7");
    apply(mk(1,0,0,0, 0,1, 0,0,1,0,1,0), "step_a8");
    apply(mk(0,1,0,0, 0,0, 1,0,1,1,0,1), "step_b0");
    apply(mk(0,0,0,0, 0,0, 1,0,1,0,0,0), "step_b1");
    apply(mk(0,0,0,0, 0,0, 1,0,1,0,0,0), "step_b2");
    apply(mk(0,0,0,0, 0,1, 0,0,1,0,1,0), "step_b3");
    apply(mk(0,0,0,0, 0,0, 0,0,1,0,0,0), "step_b4");

    // run dropped at ts10; ext/clr during FETCH and WAIT are ignored
    apply(mk(1,0,0,0, 0,0, 1,0,1,1,0,1), "drop0");
    apply(mk(1,0,0,0, 0,0, 1,0,1,0,0,0), "drop1");
    apply(mk(1,0,0,0, 0,0, 1,0,1,0,0,0), "drop2");
    apply(mk(1,0,0,0, 1,0, 1,1,2,1,0,1), "drop3");
    apply(mk(1,0,0,0, 1,1, 1,1,2,0,0,0), "drop4");
    apply(mk(1,0,0,0, 1,1, 1,1,2,0,0,0), "drop5");
    apply(mk(1,0,0,0, 0,0, 1,2,2,0,0,0), "drop6");
    apply(mk(0,0,0,0, 0,0, 1,3,2,0,0,0), "drop7");
    apply(mk(0,0,0,0, 0,1, 0,0,2,0,1,0), "drop8");
    for (int i = 0; i < 3; i++) apply(mk(0,0,0,0, 0,0, 0,0,2,0,0,0), $sformatf("drop_idle%0d", i));

    // PC wrap at 63; step ignored under run; ext+clr without stop refills
    apply(mk(1,1,1,63, 0,0, 1,0,63,1,0,1), "wrap0");
    apply(mk(1,0,0,0,  0,0, 1,0,63,0,0,0), "wrap1");
    apply(mk(1,0,0,0,  0,0, 1,0,63,0,0,0), "wrap2");
    apply(mk(1,0,0,0,  1,0, 1,1,0,1,0,1),  "wrap3");
    apply(mk(1,0,0,0,  0,0, 1,1,0,0,0,0),  "wrap4");
    apply(mk(1,0,0,0,  0,0, 1,1,0,0,0,0),  "wrap5");
    apply(mk(1,0,0,0,  0,1, 1,0,0,0,1,0),  "wrap6");
    apply(mk(1,0,0,0,  1,1, 1,0,1,1,1,1),  "wrap7");
    apply(mk(1,0,0,0,  0,0, 1,0,1,0,0,0),  "wrap8");
    apply(mk(1,0,0,0,  0,0, 1,0,1,0,0,0),  "wrap9");
    apply(mk(1,0,0,0,  0,0, 1,1,1,0,0,0),  "wrap10");
    apply(mk(1,0,0,0,  0,0, 1,2,1,0,0,0),  "wrap11");
    chk("sb", "pending", 32'(sb_q.size()), 0);

    // Asynchronous reset in the middle of EXEC at ts10
    run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset", "busy",      32'(busy),      0);
    chk("mid_reset", "timestep",  32'(timestep),  0);
    chk("mid_reset", "mem_addr",  32'(mem_addr),  0);
    chk("mid_reset", "mem_rd_en", 32'(mem_rd_en), 0);
    chk("mid_reset", "data_o",    32'(data_o),    0);
    chk("mid_reset", "instr_done", 32'(instr_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(mk(0,0,0,0, 0,0, 0,0,0,0,0,0), "post_reset");
    chk("post_reset", "data_o", 32'(data_o), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("end", "sb_pending", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
